// File: rtl/canny_pkg.sv
// Shared types and default geometry for the Canny window sequencer and its datapath.
package canny_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int unsigned IMG_W_DEF    = 520;
  localparam int unsigned IMG_H_DEF    = 520;
  localparam int unsigned ADDR_W_DEF   = 19;
  localparam int unsigned PIPE_LAT_DEF = 4;

endpackage

// File: rtl/canny_window_sequencer_if.sv
// Control pins plus the nine read-window addresses and the single write port of the sequencer.
interface canny_window_sequencer_if #(
  parameter int unsigned ADDR_W = canny_pkg::ADDR_W_DEF
);
  logic              start;
  logic              stall;
  logic              read_enable_r;
  logic [ADDR_W-1:0] add_a, add_b, add_c;
  logic [ADDR_W-1:0] add_d, add_e, add_f;
  logic [ADDR_W-1:0] add_g, add_h, add_i;
  logic              write_enable_w;
  logic [ADDR_W-1:0] write_address;
  logic              busy;
  logic              done;
  logic              mem_dump_w;
  logic              error;

  modport master (
    input  start, stall,
    output read_enable_r,
    output add_a, add_b, add_c, add_d, add_e, add_f, add_g, add_h, add_i,
    output write_enable_w, write_address, busy, done, mem_dump_w, error
  );

  modport slave (
    output start, stall,
    input  read_enable_r,
    input  add_a, add_b, add_c, add_d, add_e, add_f, add_g, add_h, add_i,
    input  write_enable_w, write_address, busy, done, mem_dump_w, error
  );
endinterface

// File: rtl/canny_valid_pipe.sv
// PIPE_LAT-deep delay line of {valid, address} with hold; index 0 is the output stage.
module canny_valid_pipe #(
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hold,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_pending
);

  logic [PIPE_LAT-1:0] r_valid;
  logic [ADDR_W-1:0]   r_addr [PIPE_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) r_addr[i] <= '0;
    end else if (!i_hold) begin
      for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
        r_valid[i] <= r_valid[i+1];
        r_addr[i]  <= r_addr[i+1];
      end
      r_valid[PIPE_LAT-1] <= i_valid;
      r_addr[PIPE_LAT-1]  <= i_addr;
    end
  end

  assign o_valid   = r_valid[0];
  assign o_addr    = r_addr[0];
  // Anything still in flight behind the output stage
  assign o_pending = |(r_valid >> 1);

endmodule

// File: rtl/canny_window_sequencer.sv
// Raster-scans interior pixels, issues 3x3 read-window addresses and a latency-aligned write strobe.
module canny_window_sequencer
  import canny_pkg::*;
#(
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned IMG_H    = IMG_H_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  canny_window_sequencer_if.master   bus
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 2);
  localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] OFS_W    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OFS_2W   = ADDR_W'(2 * IMG_W);

  seq_state_t        r_state, w_state_nxt;
  logic              r_start_q;
  logic [RW-1:0]     r_row, w_row_nxt;
  logic [CW-1:0]     r_col, w_col_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic              w_load;
  logic              w_start_rise;

  logic              r_read_en, r_busy, r_done;
  logic [ADDR_W-1:0] r_add_a, r_add_b, r_add_c;
  logic [ADDR_W-1:0] r_add_d, r_add_e, r_add_f;
  logic [ADDR_W-1:0] r_add_g, r_add_h, r_add_i;

  logic              w_pipe_valid, w_pipe_pending;
  logic [ADDR_W-1:0] w_pipe_addr;

  assign w_start_rise = bus.start & ~r_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus scan position; base only moves when a new window is loaded
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_base_nxt  = r_base;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = RUN;
          w_row_nxt   = RW'(1);
          w_col_nxt   = CW'(1);
          w_base_nxt  = '0;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          if (r_row == ROW_LAST && r_col == COL_LAST) begin
            w_state_nxt = DRAIN;
          end else if (r_col == COL_LAST) begin
            w_col_nxt  = CW'(1);
            w_row_nxt  = r_row + RW'(1);
            w_base_nxt = r_base + ADDR_W'(3);
            w_load     = 1'b1;
          end else begin
            w_col_nxt  = r_col + CW'(1);
            w_base_nxt = r_base + ADDR_W'(1);
            w_load     = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!bus.stall && !w_pipe_pending) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_base    <= '0;
      r_read_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_add_a   <= '0; r_add_b <= '0; r_add_c <= '0;
      r_add_d   <= '0; r_add_e <= '0; r_add_f <= '0;
      r_add_g   <= '0; r_add_h <= '0; r_add_i <= '0;
    end else begin
      r_start_q <= bus.start;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_base    <= w_base_nxt;
      r_read_en <= (w_state_nxt == RUN);
      r_busy    <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      r_done    <= (w_state_nxt == DONE);
      if (w_load) begin
        r_add_a <= w_base_nxt;
        r_add_b <= w_base_nxt + ADDR_W'(1);
        r_add_c <= w_base_nxt + ADDR_W'(2);
        r_add_d <= w_base_nxt + OFS_W;
        r_add_e <= w_base_nxt + OFS_W + ADDR_W'(1);
        r_add_f <= w_base_nxt + OFS_W + ADDR_W'(2);
        r_add_g <= w_base_nxt + OFS_2W;
        r_add_h <= w_base_nxt + OFS_2W + ADDR_W'(1);
        r_add_i <= w_base_nxt + OFS_2W + ADDR_W'(2);
      end
    end
  end

  // Every RUN cycle presents a window; the centre address rides the pipe to the write port
  canny_valid_pipe #(
    .PIPE_LAT (PIPE_LAT),
    .ADDR_W   (ADDR_W)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .i_hold    (bus.stall),
    .i_valid   (r_state == RUN),
    .i_addr    (r_add_e),
    .o_valid   (w_pipe_valid),
    .o_addr    (w_pipe_addr),
    .o_pending (w_pipe_pending)
  );

  assign bus.read_enable_r  = r_read_en;
  assign bus.add_a          = r_add_a;
  assign bus.add_b          = r_add_b;
  assign bus.add_c          = r_add_c;
  assign bus.add_d          = r_add_d;
  assign bus.add_e          = r_add_e;
  assign bus.add_f          = r_add_f;
  assign bus.add_g          = r_add_g;
  assign bus.add_h          = r_add_h;
  assign bus.add_i          = r_add_i;
  // A stalled cycle must not commit a result even if one is at the pipe output
  assign bus.write_enable_w = w_pipe_valid & ~bus.stall;
  assign bus.write_address  = w_pipe_addr;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.mem_dump_w     = r_done;
  assign bus.error          = w_start_rise & r_busy;

endmodule

// File: tb/tb_canny_window_sequencer.sv
// Directed bench: 5x4 image, PIPE_LAT=4, plus a default-geometry instance for first-window checks.
module tb_canny_window_sequencer;
  import canny_pkg::*;

  localparam int unsigned W  = 5;
  localparam int unsigned H  = 4;
  localparam int unsigned L  = 4;
  localparam int unsigned AW = 8;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  canny_window_sequencer_if #(.ADDR_W(AW))         bus ();
  canny_window_sequencer_if #(.ADDR_W(ADDR_W_DEF)) dbus ();

  assign dbus.start = bus.start;
  assign dbus.stall = bus.stall;

  canny_window_sequencer #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIPE_LAT(L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  canny_window_sequencer dut_def (
    .clk (clk),
    .rst (rst),
    .bus (dbus)
  );

  int vecs = 0;
  int errs = 0;

  logic [31:0] a_log    [0:N];
  logic [31:0] e_log    [0:N];
  logic [31:0] i_log    [0:N];
  logic [31:0] re_log   [0:N];
  logic [31:0] we_log   [0:N];
  logic [31:0] wa_log   [0:N];
  logic [31:0] done_log [0:N];
  logic [31:0] dump_log [0:N];
  logic [31:0] busy_log [0:N];
  logic [31:0] err_log  [0:N];
  logic [31:0] da1, de1, di1, dwe5, dwa5;

  int exp_wa [6] = '{6, 7, 8, 11, 12, 13};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ones(input logic [31:0] lg [0:N]);
    int n = 0;
    for (int c = 0; c <= N; c++) if (lg[c] === 32'd1) n++;
    return n;
  endfunction

  // Start edge in cycle 0, then log cycles 1..N; start high through hold_to and at pulse_at
  task automatic run(input int hold_to, input int pulse_at, input int s_from, input int s_to);
    bus.start = 1'b1;
    bus.stall = 1'b0;
    #1;
    err_log[0] = 32'(bus.error);
    for (int c = 1; c <= N; c++) begin
      tick();
      bus.start = (c <= hold_to) || (c == pulse_at);
      bus.stall = (c >= s_from) && (c <= s_to);
      #1;
      a_log[c]    = 32'(bus.add_a);
      e_log[c]    = 32'(bus.add_e);
      i_log[c]    = 32'(bus.add_i);
      re_log[c]   = 32'(bus.read_enable_r);
      we_log[c]   = 32'(bus.write_enable_w);
      wa_log[c]   = 32'(bus.write_address);
      done_log[c] = 32'(bus.done);
      dump_log[c] = 32'(bus.mem_dump_w);
      busy_log[c] = 32'(bus.busy);
      err_log[c]  = 32'(bus.error);
      if (c == 1) begin
        da1 = 32'(dbus.add_a);
        de1 = 32'(dbus.add_e);
        di1 = 32'(dbus.add_i);
      end
      if (c == 5) begin
        dwe5 = 32'(dbus.write_enable_w);
        dwa5 = 32'(dbus.write_address);
      end
    end
    tick();
    bus.start = 1'b0;
    bus.stall = 1'b0;
  endtask

  task automatic chk_writes(input string tag, input int first_cyc);
    int q[$];
    int fc = -1;
    for (int c = 1; c <= N; c++) begin
      if (we_log[c] === 32'd1) begin
        q.push_back(int'(wa_log[c]));
        if (fc < 0) fc = c;
      end
    end
    chk({tag, "_wr_count"}, 32'(q.size()), 32'd6);
    chk({tag, "_wr_first_cycle"}, 32'(fc), 32'(first_cyc));
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_wr_addr%0d", tag, k), (k < q.size()) ? 32'(q[k]) : 32'hFFFF_FFFF, 32'(exp_wa[k]));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) tick();

    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_re",    32'(bus.read_enable_r), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_dump",  32'(bus.mem_dump_w), 32'd0);
    chk("rst_we",    32'(bus.write_enable_w), 32'd0);
    chk("rst_wa",    32'(bus.write_address), 32'd0);
    chk("rst_add_i", 32'(bus.add_i), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);

    rst = 1'b0;
    tick();
    tick();

    // Nominal frame
    run(0, 0, 0, -1);
    chk("nom_a1",      a_log[1], 32'd0);
    chk("nom_e1",      e_log[1], 32'd6);
    chk("nom_i1",      i_log[1], 32'd12);
    chk("nom_re1",     re_log[1], 32'd1);
    chk("nom_busy1",   busy_log[1], 32'd1);
    chk("nom_a3",      a_log[3], 32'd2);
    chk("nom_a4_rowend", a_log[4], 32'd5);
    chk("nom_a6",      a_log[6], 32'd7);
    chk("nom_e6",      e_log[6], 32'd13);
    chk("nom_i6",      i_log[6], 32'd19);
    chk("nom_re7",     re_log[7], 32'd0);
    chk_writes("nom", 5);
    chk("nom_done11",  done_log[11], 32'd1);
    chk("nom_dump11",  dump_log[11], 32'd1);
    chk("nom_done_cnt", 32'(ones(done_log)), 32'd1);
    chk("nom_busy10",  busy_log[10], 32'd1);
    chk("nom_busy11",  busy_log[11], 32'd0);
    chk("nom_err_cnt", 32'(ones(err_log)), 32'd0);
    chk("def_a1",      da1, 32'd0);
    chk("def_e1",      de1, 32'd521);
    chk("def_i1",      di1, 32'd1042);
    chk("def_we5",     dwe5, 32'd1);
    chk("def_wa5",     dwa5, 32'd521);
    tick();

    // Two-cycle stall at the third window
    run(0, 0, 3, 4);
    chk("stl_a3",      a_log[3], 32'd2);
    chk("stl_a4",      a_log[4], 32'd2);
    chk("stl_a5",      a_log[5], 32'd2);
    chk("stl_a6",      a_log[6], 32'd5);
    chk("stl_re4",     re_log[4], 32'd1);
    chk_writes("stl", 7);
    chk("stl_done11",  done_log[11], 32'd0);
    chk("stl_done13",  done_log[13], 32'd1);
    chk("stl_done_cnt", 32'(ones(done_log)), 32'd1);
    tick();

    // Stall in DRAIN while a result sits at the write port
    run(0, 0, 8, 8);
    chk("drn_we8",     we_log[8], 32'd0);
    chk("drn_we9",     we_log[9], 32'd1);
    chk("drn_wa9",     wa_log[9], 32'd11);
    chk("drn_done12",  done_log[12], 32'd1);
    chk("drn_done_cnt", 32'(ones(done_log)), 32'd1);
    tick();

    // Start held three cycles, then a fresh edge in cycle 5
    run(2, 5, 0, -1);
    chk("hold_err5",    err_log[5], 32'd1);
    chk("hold_err_cnt", 32'(ones(err_log)), 32'd1);
    chk("hold_done11",  done_log[11], 32'd1);
    chk("hold_done_cnt", 32'(ones(done_log)), 32'd1);
    chk("hold_busy14",  busy_log[14], 32'd0);
    chk("hold_re14",    re_log[14], 32'd0);
    tick();

    // Reset in cycle 4 of a frame, then a full restart
    bus.start = 1'b1;
    #1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      bus.start = 1'b0;
    end
    chk("abort_busy3", 32'(bus.busy), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_re",    32'(bus.read_enable_r), 32'd0);
    chk("abort_add_a", 32'(bus.add_a), 32'd0);
    chk("abort_add_e", 32'(bus.add_e), 32'd0);
    chk("abort_we",    32'(bus.write_enable_w), 32'd0);
    chk("abort_done",  32'(bus.done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run(0, 0, 0, -1);
    chk("rs_a1",     a_log[1], 32'd0);
    chk("rs_re1",    re_log[1], 32'd1);
    chk("rs_a2",     a_log[2], 32'd1);
    chk_writes("rs", 5);
    chk("rs_done11", done_log[11], 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
